// File: rtl/weight_arb_pkg.sv
// Shared types, default sizes and the wrap-around round-robin search for the SRAM arbiters.
`ifndef WEIGHT_SRAM_LEN
`define WEIGHT_SRAM_LEN 64
`endif

package weight_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_NUM_PU   = 4;
  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_WORD_W   = `WEIGHT_SRAM_LEN;
  localparam int unsigned DEF_SRAM_LAT = 2;
  localparam int unsigned RR_MAX       = 16;

  // Returns {valid, index}: first set bit of req at or above ptr, wrapping modulo n (n a power of two).
  function automatic logic [4:0] rr_search(input logic [RR_MAX-1:0] req,
                                           input logic [3:0] ptr,
                                           input int unsigned n);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = 4'((32'(ptr) + k) & (n - 1));
      if (k < n && !res[4] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/weight_sram_arbiter_rr_grant.sv
// Combinational round-robin picker; reusable by any N-way single-port SRAM arbiter.
module rr_grant
  import weight_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int unsigned IW = $clog2(N);

  logic [4:0] res;
  logic       unused_res;

  always_comb begin
    res         = rr_search(16'(req), 4'(rr_ptr), N);
    grant_valid = res[4];
    grant_idx   = res[IW-1:0];
  end

  assign unused_res = ^res;

endmodule

// File: rtl/weight_sram_arbiter.sv
// Round-robin arbiter sharing one weight-SRAM read port between NUM_PU buffers.
// Define WEIGHT_ARB_STATS_EN to add grant_count / stall_count statistics outputs.
module weight_sram_arbiter
  import weight_arb_pkg::*;
#(
  parameter int unsigned NUM_PU   = DEF_NUM_PU,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned SRAM_LAT = DEF_SRAM_LAT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_PU-1:0]        word_read,
  input  logic [NUM_PU*32-1:0]     word_counter,
  input  logic [NUM_PU-1:0]        pu_enable,
  input  logic [NUM_PU*ADDR_W-1:0] stream_base,
  output logic [NUM_PU-1:0]        word_ready,
  output logic [WORD_W-1:0]        SRAM_out,
  output logic                     sram_en,
  output logic [ADDR_W-1:0]        sram_addr,
  input  logic [WORD_W-1:0]        sram_rdata,
  output logic                     busy
`ifdef WEIGHT_ARB_STATS_EN
  ,
  output logic [NUM_PU*32-1:0]     grant_count,
  output logic [31:0]              stall_count
`endif
);

  localparam int unsigned IW       = $clog2(NUM_PU);
  localparam logic [1:0]  LAT_INIT = 2'(SRAM_LAT - 1);

  arb_state_t          state;
  logic [IW-1:0]       g;
  logic [IW-1:0]       rr_ptr;
  logic [1:0]          lat_cnt;
  logic [WORD_W-1:0]   data_q;

  logic [IW-1:0]       sel_idx;
  logic                sel_valid;
  logic                req_g;
  logic                en_g;
  logic                deliver_done;
  logic [ADDR_W-1:0]   base_g;
  logic [ADDR_W-1:0]   cnt_g;

  rr_grant #(.N(NUM_PU)) u_rr_grant (
    .req         (word_read),
    .rr_ptr      (rr_ptr),
    .grant_idx   (sel_idx),
    .grant_valid (sel_valid)
  );

  always_comb begin
    req_g        = word_read[g];
    en_g         = pu_enable[g];
    base_g       = stream_base[g*ADDR_W +: ADDR_W];
    cnt_g        = word_counter[g*32 +: ADDR_W];
    deliver_done = (state == DELIVER) && req_g && en_g;
  end

  // Every non-IDLE state drops the transaction as soon as the granted request falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      g       <= '0;
      rr_ptr  <= '0;
      lat_cnt <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            g     <= sel_idx;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!req_g) state <= IDLE;
          else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!req_g) state <= IDLE;
          else if (lat_cnt == 2'd0) begin
            data_q <= sram_rdata;
            state  <= DELIVER;
          end else lat_cnt <= lat_cnt - 2'd1;
        end
        DELIVER: begin
          if (!req_g) state <= IDLE;
          else if (en_g) begin
            rr_ptr <= g + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    sram_en    = (state == ISSUE);
    sram_addr  = (state == ISSUE) ? (base_g + cnt_g) : '0;
    SRAM_out   = data_q;
    word_ready = '0;
    if (state == DELIVER && req_g) word_ready[g] = 1'b1;
  end

`ifdef WEIGHT_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_count <= '0;
      stall_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PU; i++) begin
        if (deliver_done && 32'(g) == i && grant_count[i*32 +: 32] != '1)
          grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
      end
      if (|word_read && state != IDLE && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_sram_arbiter.sv
// Directed self-checking bench for weight_sram_arbiter with a 2-cycle SRAM model.
module tb_weight_sram_arbiter;

  localparam int unsigned NUM_PU   = 4;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SRAM_LAT = 2;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NUM_PU-1:0]        word_read = '0;
  logic [NUM_PU*32-1:0]     word_counter = '0;
  logic [NUM_PU-1:0]        pu_enable = '1;
  logic [NUM_PU*ADDR_W-1:0] stream_base = '0;
  logic [NUM_PU-1:0]        word_ready;
  logic [WORD_W-1:0]        SRAM_out;
  logic                     sram_en;
  logic [ADDR_W-1:0]        sram_addr;
  logic [WORD_W-1:0]        sram_rdata;
  logic                     busy;
`ifdef WEIGHT_ARB_STATS_EN
  logic [NUM_PU*32-1:0]     grant_count;
  logic [31:0]              stall_count;
`endif

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  weight_sram_arbiter #(
    .NUM_PU   (NUM_PU),
    .ADDR_W   (ADDR_W),
    .WORD_W   (WORD_W),
    .SRAM_LAT (SRAM_LAT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .word_read    (word_read),
    .word_counter (word_counter),
    .pu_enable    (pu_enable),
    .stream_base  (stream_base),
    .word_ready   (word_ready),
    .SRAM_out     (SRAM_out),
    .sram_en      (sram_en),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .busy         (busy)
`ifdef WEIGHT_ARB_STATS_EN
    ,
    .grant_count  (grant_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] sram_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Two-stage SRAM: data valid SRAM_LAT cycles after sram_en, garbage otherwise.
  logic        p1_v = 1'b0;
  logic [15:0] p1_a = '0;
  always @(posedge clock) begin
    cyc_cnt    <= cyc_cnt + 1;
    p1_v       <= sram_en;
    p1_a       <= sram_addr;
    sram_rdata <= p1_v ? sram_word(p1_a) : 32'hDEAD_BEEF;
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    tests++;
    if ({word_ready, SRAM_out, sram_en, sram_addr, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b out=%h en=%b addr=%h busy=%b, required all zero",
               word_ready, SRAM_out, sram_en, sram_addr, busy);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clock); #1;
    stream_base[1*16 +: 16] = 16'h0100;
    word_counter[1*32 +: 32] = 32'd3;
    word_read = 4'b0010;
    @(negedge clock);
    tests++;
    if (busy !== 1'b0 || sram_en !== 1'b0) begin
      fails++; $display("FAIL single_c0: busy=%b en=%b, required 0 0", busy, sram_en);
    end
    @(negedge clock);
    tests++;
    if (sram_en !== 1'b1 || sram_addr !== 16'h0103) begin
      fails++; $display("FAIL single_issue: en=%b addr=%h, required 1 0103", sram_en, sram_addr);
    end
    @(negedge clock);
    tests++;
    if (word_ready !== 4'b0000 || busy !== 1'b1 || sram_en !== 1'b0) begin
      fails++; $display("FAIL single_c2: ready=%b busy=%b en=%b, required 0000 1 0", word_ready, busy, sram_en);
    end
    @(negedge clock);
    tests++;
    if (word_ready !== 4'b0000) begin
      fails++; $display("FAIL single_c3: ready=%b, required 0000", word_ready);
    end
    @(negedge clock);
    tests++;
    if (word_ready !== 4'b0010 || SRAM_out !== sram_word(16'h0103)) begin
      fails++; $display("FAIL single_deliver: ready=%b out=%h, required 0010 %h",
                        word_ready, SRAM_out, sram_word(16'h0103));
    end
    @(posedge clock); #1;
    word_read = 4'b0000;
    @(negedge clock);
    tests++;
    if (word_ready !== 4'b0000 || busy !== 1'b0) begin
      fails++; $display("FAIL single_done: ready=%b busy=%b, required 0000 0", word_ready, busy);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int last;
    logic [15:0] a;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stream_base[i*16 +: 16] = 16'(16'h1000 * (i + 1));
      word_counter[i*32 +: 32] = 32'(i);
    end
    word_read = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      int exp_pu;
      exp_pu = k % 4;
      n = 0;
      while (word_ready == '0 && n < 12) begin @(negedge clock); n++; end
      a = 16'(16'h1000 * (exp_pu + 1) + exp_pu);
      tests++;
      if (word_ready !== 4'(1 << exp_pu) || SRAM_out !== sram_word(a)) begin
        fails++; $display("FAIL rr_grant_%0d: ready=%b out=%h, required %b %h",
                          k, word_ready, SRAM_out, 4'(1 << exp_pu), sram_word(a));
      end
      if (k > 0 && k < 4) begin
        tests++;
        if (cyc_cnt - last !== 5) begin
          fails++; $display("FAIL rr_spacing_%0d: %0d cycles, required 5", k, cyc_cnt - last);
        end
      end
      last = cyc_cnt;
      @(posedge clock); #1;
      word_read[exp_pu] = 1'b0;
      if (k == 3) word_read[0] = 1'b1;
    end
  endtask

  task automatic test_hold();
    int n;
    logic [WORD_W-1:0] held;
    logic stable;
    @(posedge clock); #1;
    stream_base[2*16 +: 16] = 16'h2000;
    word_counter[2*32 +: 32] = 32'd2;
    pu_enable = 4'b1011;
    word_read = 4'b0100;
    n = 0;
    while (word_ready == '0 && n < 12) begin @(negedge clock); n++; end
    tests++;
    if (word_ready !== 4'b0100 || SRAM_out !== sram_word(16'h2002)) begin
      fails++; $display("FAIL hold_first: ready=%b out=%h, required 0100 %h",
                        word_ready, SRAM_out, sram_word(16'h2002));
    end
    held = sram_word(16'h2002);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (word_ready !== 4'b0100 || SRAM_out !== held) stable = 1'b0;
    end
    tests++;
    if (stable !== 1'b1) begin
      fails++; $display("FAIL hold_stable: ready=%b out=%h, required 0100 %h held", word_ready, SRAM_out, held);
    end
    @(posedge clock); #1;
    pu_enable = 4'b1111;
    @(negedge clock);
    tests++;
    if (word_ready !== 4'b0100) begin
      fails++; $display("FAIL hold_enable_cycle: ready=%b, required 0100", word_ready);
    end
    @(posedge clock); #1;
    word_read = 4'b0000;
    @(negedge clock);
    tests++;
    if (word_ready !== 4'b0000 || busy !== 1'b0) begin
      fails++; $display("FAIL hold_release: ready=%b busy=%b, required 0000 0", word_ready, busy);
    end
  endtask

  task automatic test_wrap();
    int n;
    @(posedge clock); #1;
    stream_base[0 +: 16] = 16'hFFFF;
    word_counter[0 +: 32] = 32'd2;
    word_read = 4'b0001;
    n = 0;
    while (sram_en !== 1'b1 && n < 8) begin @(negedge clock); n++; end
    tests++;
    if (sram_en !== 1'b1 || sram_addr !== 16'h0001) begin
      fails++; $display("FAIL wrap_addr: en=%b addr=%h, required 1 0001", sram_en, sram_addr);
    end
    n = 0;
    while (word_ready == '0 && n < 8) begin @(negedge clock); n++; end
    tests++;
    if (word_ready !== 4'b0001 || SRAM_out !== sram_word(16'h0001)) begin
      fails++; $display("FAIL wrap_data: ready=%b out=%h, required 0001 %h",
                        word_ready, SRAM_out, sram_word(16'h0001));
    end
    @(posedge clock); #1;
    word_read = 4'b0000;
  endtask

  task automatic test_abort();
    int n;
    logic quiet;
    @(posedge clock); #1;
    stream_base[3*16 +: 16] = 16'h3000;
    word_counter[3*32 +: 32] = 32'd7;
    word_read = 4'b1000;
    @(negedge clock);
    @(negedge clock);
    @(posedge clock); #1;
    word_read = 4'b0000;
    @(negedge clock);
    tests++;
    if (busy !== 1'b1 || word_ready !== 4'b0000) begin
      fails++; $display("FAIL abort_wait: busy=%b ready=%b, required 1 0000", busy, word_ready);
    end
    @(negedge clock);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL abort_idle: busy=%b, required 0", busy);
    end
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (word_ready !== 4'b0000 || busy !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (quiet !== 1'b1) begin
      fails++; $display("FAIL abort_no_ready: ready=%b busy=%b, required 0000 0", word_ready, busy);
    end
    @(posedge clock); #1;
    stream_base[0 +: 16] = 16'h0040;
    word_counter[0 +: 32] = 32'hABCD_0005;
    word_read = 4'b0001;
    n = 0;
    while (word_ready == '0 && n < 12) begin @(negedge clock); n++; end
    tests++;
    if (word_ready !== 4'b0001 || SRAM_out !== sram_word(16'h0045)) begin
      fails++; $display("FAIL abort_next: ready=%b out=%h, required 0001 %h",
                        word_ready, SRAM_out, sram_word(16'h0045));
    end
    @(posedge clock); #1;
    word_read = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int n;
    @(posedge clock); #1;
    pu_enable = 4'b1101;
    word_read = 4'b0010;
    n = 0;
    while (word_ready == '0 && n < 12) begin @(negedge clock); n++; end
    tests++;
    if (word_ready !== 4'b0010) begin
      fails++; $display("FAIL rstmid_deliver: ready=%b, required 0010", word_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (word_ready !== 4'b0000 || sram_en !== 1'b0 || busy !== 1'b0 || SRAM_out !== '0) begin
      fails++; $display("FAIL rstmid_async: ready=%b en=%b busy=%b out=%h, required 0000 0 0 0",
                        word_ready, sram_en, busy, SRAM_out);
    end
    word_read = 4'b0011;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    pu_enable = 4'b1111;
    n = 0;
    while (word_ready == '0 && n < 12) begin @(negedge clock); n++; end
    tests++;
    if (word_ready !== 4'b0001) begin
      fails++; $display("FAIL rstmid_first_grant: ready=%b, required 0001", word_ready);
    end
    @(posedge clock); #1;
    word_read = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_wrap();
    test_abort();
    test_reset_mid();
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
